// File: rtl/select_pkg.sv
// Shared types and sizing helpers for the pipelined minimum-energy selector.
package select_pkg;

  typedef logic signed [1:0] sym_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int sel_latency(input int l, input int r);
    return (l == 0) ? 1 : 1 + (l - 1) / r;
  endfunction

  // All-ones energy of width w, so a pad can only tie a real state.
  function automatic logic [63:0] pad_energy(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/select_node.sv
// Two-input compare: strictly smaller energy wins, ties go to lower index.
module select_node
  import select_pkg::*;
#(
  parameter int EW      = 16,
  parameter int H_DEPTH = 4,
  parameter int IDX_W   = 3
) (
  input  logic [EW-1:0]           a_energy,
  input  logic [H_DEPTH-1:0][1:0] a_history,
  input  logic [IDX_W-1:0]        a_index,
  input  logic [EW-1:0]           b_energy,
  input  logic [H_DEPTH-1:0][1:0] b_history,
  input  logic [IDX_W-1:0]        b_index,
  output logic [EW-1:0]           y_energy,
  output logic [H_DEPTH-1:0][1:0] y_history,
  output logic [IDX_W-1:0]        y_index
);

  logic take_b;

  assign take_b = (b_energy < a_energy) ||
                  ((b_energy == a_energy) && (b_index < a_index));

  assign y_energy  = take_b ? b_energy  : a_energy;
  assign y_history = take_b ? b_history : a_history;
  assign y_index   = take_b ? b_index   : a_index;

endmodule

// File: rtl/pipelined_select_unit.sv
// Pipelined N-way minimum-energy selector with padding, hold and valid chain.
module pipelined_select_unit
  import select_pkg::*;
#(
  parameter  int N_S       = 8,
  parameter  int H_DEPTH   = 4,
  parameter  int B_WIDTH   = 8,
  parameter  int REG_EVERY = 1,
  localparam int IDX_W     = idx_w(N_S)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                hold,
  input  logic                                in_valid,
  input  logic [N_S-1:0][2*B_WIDTH-1:0]       state_energies,
  input  logic [N_S-1:0][H_DEPTH-1:0][1:0]    state_histories,
  output logic                                out_valid,
  output logic [2*B_WIDTH-1:0]                best_state_energy,
  output logic [H_DEPTH-1:0][1:0]             best_state_history,
  output logic [IDX_W-1:0]                    best_state_index
);

  localparam int EW = 2 * B_WIDTH;
  localparam int L  = tree_levels(N_S);
  localparam int NP = 1 << L;

  typedef logic [EW-1:0]      energy_t;
  typedef sym_t [H_DEPTH-1:0] hist_t;
  typedef logic [IDX_W-1:0]   index_t;

  localparam energy_t PAD_E = energy_t'(pad_energy(EW));

  energy_t lv_e [0:L][0:NP-1];
  hist_t   lv_h [0:L][0:NP-1];
  index_t  lv_i [0:L][0:NP-1];
  logic    lv_v [0:L];

  assign lv_v[0] = in_valid;

  for (genvar j = 0; j < NP; j++) begin : g_pad
    if (j < N_S) begin : g_real
      assign lv_e[0][j] = state_energies[j];
      assign lv_h[0][j] = state_histories[j];
    end else begin : g_fill
      assign lv_e[0][j] = PAD_E;
      assign lv_h[0][j] = '0;
    end
    assign lv_i[0][j] = index_t'(j);
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int W = NP >> k;

    energy_t c_e [W];
    hist_t   c_h [W];
    index_t  c_i [W];

    for (genvar j = 0; j < W; j++) begin : g_node
      select_node #(
        .EW      (EW),
        .H_DEPTH (H_DEPTH),
        .IDX_W   (IDX_W)
      ) u_node (
        .a_energy  (lv_e[k-1][2*j]),
        .a_history (lv_h[k-1][2*j]),
        .a_index   (lv_i[k-1][2*j]),
        .b_energy  (lv_e[k-1][2*j+1]),
        .b_history (lv_h[k-1][2*j+1]),
        .b_index   (lv_i[k-1][2*j+1]),
        .y_energy  (c_e[j]),
        .y_history (c_h[j]),
        .y_index   (c_i[j])
      );
    end

    if (k < L && (k % REG_EVERY) == 0) begin : g_reg
      energy_t r_e [W];
      hist_t   r_h [W];
      index_t  r_i [W];
      logic    r_v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
        end else if (!hold) begin
          r_v <= lv_v[k-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < W; j++) begin
            r_e[j] <= '0;
            r_h[j] <= '0;
            r_i[j] <= '0;
          end
        end else if (lv_v[k-1] && !hold) begin
          r_e <= c_e;
          r_h <= c_h;
          r_i <= c_i;
        end
      end

      assign lv_v[k] = r_v;
      for (genvar j = 0; j < W; j++) begin : g_out
        assign lv_e[k][j] = r_e[j];
        assign lv_h[k][j] = r_h[j];
        assign lv_i[k][j] = r_i[j];
      end
    end else begin : g_comb
      assign lv_v[k] = lv_v[k-1];
      for (genvar j = 0; j < W; j++) begin : g_out
        assign lv_e[k][j] = c_e[j];
        assign lv_h[k][j] = c_h[j];
        assign lv_i[k][j] = c_i[j];
      end
    end

    // Upper slots of a narrowed level carry nothing.
    for (genvar j = W; j < NP; j++) begin : g_zero
      assign lv_e[k][j] = '0;
      assign lv_h[k][j] = '0;
      assign lv_i[k][j] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid          <= 1'b0;
      best_state_energy  <= '0;
      best_state_history <= '0;
      best_state_index   <= '0;
    end else if (!hold) begin
      out_valid <= lv_v[L];
      if (lv_v[L]) begin
        best_state_energy  <= lv_e[L][0];
        best_state_history <= lv_h[L][0];
        best_state_index   <= lv_i[L][0];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_select_unit.sv
// Scoreboard bench for pipelined_select_unit at N_S = 8, 5, 1 and 2.
module tb_pipelined_select_unit;

  typedef struct {
    logic [15:0] e;
    logic [7:0]  h;
    logic [2:0]  i;
    int          due;
  } exp_t;

  localparam int NS  [4] = '{8, 5, 1, 2};
  localparam int LAT [4] = '{3, 3, 1, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic [3:0] iv = '0;

  logic [15:0] en [4][8];
  logic [7:0]  hs [4][8];

  logic [7:0][15:0] se8;
  logic [7:0][7:0]  sh8;
  logic [4:0][15:0] se5;
  logic [4:0][7:0]  sh5;
  logic [0:0][15:0] se1;
  logic [0:0][7:0]  sh1;
  logic [1:0][15:0] se2;
  logic [1:0][7:0]  sh2;

  logic [3:0]  ov;
  logic [15:0] be [4];
  logic [7:0]  bh [4];
  logic [2:0]  bi8, bi5;
  logic [0:0]  bi1, bi2;

  exp_t q [4][$];
  logic        xo [4];
  logic [15:0] xe [4];
  logic [7:0]  xh [4];
  logic [2:0]  xi [4];
  int          pact [4];
  int          act = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      se8[j] = en[0][j];
      sh8[j] = hs[0][j];
    end
    for (int j = 0; j < 5; j++) begin
      se5[j] = en[1][j];
      sh5[j] = hs[1][j];
    end
    se1[0] = en[2][0];
    sh1[0] = hs[2][0];
    for (int j = 0; j < 2; j++) begin
      se2[j] = en[3][j];
      sh2[j] = hs[3][j];
    end
  end

  pipelined_select_unit #(.N_S(8), .REG_EVERY(1)) u8 (
    .clk(clk), .rst(rst), .hold(hold), .in_valid(iv[0]),
    .state_energies(se8), .state_histories(sh8),
    .out_valid(ov[0]), .best_state_energy(be[0]),
    .best_state_history(bh[0]), .best_state_index(bi8)
  );

  pipelined_select_unit #(.N_S(5), .REG_EVERY(1)) u5 (
    .clk(clk), .rst(rst), .hold(hold), .in_valid(iv[1]),
    .state_energies(se5), .state_histories(sh5),
    .out_valid(ov[1]), .best_state_energy(be[1]),
    .best_state_history(bh[1]), .best_state_index(bi5)
  );

  pipelined_select_unit #(.N_S(1), .REG_EVERY(1)) u1 (
    .clk(clk), .rst(rst), .hold(hold), .in_valid(iv[2]),
    .state_energies(se1), .state_histories(sh1),
    .out_valid(ov[2]), .best_state_energy(be[2]),
    .best_state_history(bh[2]), .best_state_index(bi1)
  );

  pipelined_select_unit #(.N_S(2), .REG_EVERY(1)) u2 (
    .clk(clk), .rst(rst), .hold(hold), .in_valid(iv[3]),
    .state_energies(se2), .state_histories(sh2),
    .out_valid(ov[3]), .best_state_energy(be[3]),
    .best_state_history(bh[3]), .best_state_index(bi2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int d, input int due);
    exp_t r;
    int   b = 0;
    for (int j = 1; j < NS[d]; j++)
      if (en[d][j] < en[d][b]) b = j;
    r.e   = en[d][b];
    r.h   = hs[d][b];
    r.i   = 3'(b);
    r.due = due;
    return r;
  endfunction

  task automatic send(input int d);
    iv[d] = 1'b1;
    if (!hold) q[d].push_back(model(d, act + LAT[d]));
  endtask

  task automatic mon(input int d, input logic o, input logic [15:0] e,
                     input logic [7:0] h, input logic [2:0] i);
    exp_t x;
    if (act != pact[d]) begin
      if (q[d].size() > 0 && q[d][0].due == act) begin
        x = q[d].pop_front();
        xo[d] = 1'b1;
        xe[d] = x.e;
        xh[d] = x.h;
        xi[d] = x.i;
      end else begin
        xo[d] = 1'b0;
      end
      pact[d] = act;
    end
    chk($sformatf("valid%0d", d), 32'(o), 32'(xo[d]));
    chk($sformatf("energy%0d", d), 32'(e), 32'(xe[d]));
    chk($sformatf("hist%0d", d), 32'(h), 32'(xh[d]));
    chk($sformatf("index%0d", d), 32'(i), 32'(xi[d]));
  endtask

  always @(posedge clk)
    if (!rst && !hold) act <= act + 1;

  always @(negedge clk)
    if (!rst) begin
      mon(0, ov[0], be[0], bh[0], bi8);
      mon(1, ov[1], be[1], bh[1], bi5);
      mon(2, ov[2], be[2], bh[2], {2'b00, bi1});
      mon(3, ov[3], be[3], bh[3], {2'b00, bi2});
    end

  task automatic step();
    @(negedge clk);
    iv = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_v"}, 32'(ov), 32'd0);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_e%0d", tag, d), 32'(be[d]), 32'd0);
      chk($sformatf("%s_h%0d", tag, d), 32'(bh[d]), 32'd0);
    end
    chk({tag, "_i"}, {26'd0, bi8, bi5}, 32'd0);
    chk({tag, "_i12"}, {30'd0, bi1, bi2}, 32'd0);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 4; d++) begin
      q[d].delete();
      xo[d] = 1'b0;
      xe[d] = '0;
      xh[d] = '0;
      xi[d] = '0;
      pact[d] = act;
    end
  endtask

  task automatic rand_set(input int d);
    int p;
    for (int j = 0; j < 8; j++) begin
      en[d][j] = 16'($urandom_range(1000, 60000));
      hs[d][j] = 8'($urandom);
    end
    p = $urandom_range(0, NS[d] - 1);
    en[d][p] = 16'($urandom_range(0, 999));
  endtask

  initial begin
    for (int d = 0; d < 4; d++)
      for (int j = 0; j < 8; j++) begin
        en[d][j] = '0;
        hs[d][j] = '0;
      end
    clear_model();
    #1;
    check_zero("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();

    // Single pulse with tied minimum at slots 5 and 6.
    step();
    en[0] = '{16'd90, 16'd40, 16'd70, 16'd40,
              16'd200, 16'd15, 16'd15, 16'd300};
    for (int j = 0; j < 8; j++) hs[0][j] = 8'(8'h11 * j + 8'h03);
    send(0);
    // All-max energies on the padded 5-way tree.
    for (int j = 0; j < 5; j++) begin
      en[1][j] = 16'hFFFF;
      hs[1][j] = 8'(8'hA0 + j * 7);
    end
    send(1);
    en[2][0] = 16'd1234;
    hs[2][0] = 8'h5A;
    send(2);
    en[3][0] = 16'd7;
    en[3][1] = 16'd7;
    hs[3][0] = 8'h3C;
    hs[3][1] = 8'hC3;
    send(3);
    repeat (6) step();

    step();
    en[3][0] = 16'd9;
    en[3][1] = 16'd3;
    send(3);
    repeat (3) step();

    // Back-to-back stream of ten sets.
    for (int n = 0; n < 10; n++) begin
      step();
      rand_set(0);
      rand_set(1);
      send(0);
      send(1);
    end
    repeat (6) step();

    // Two in flight, then hold with junk valid inputs.
    for (int n = 0; n < 2; n++) begin
      step();
      rand_set(0);
      send(0);
    end
    for (int n = 0; n < 4; n++) begin
      step();
      hold = 1'b1;
      for (int j = 0; j < 8; j++) en[0][j] = 16'd1;
      en[0][2] = 16'd0;
      send(0);
    end
    step();
    hold = 1'b0;
    repeat (6) step();

    // Reset with three results in flight.
    for (int n = 0; n < 3; n++) begin
      step();
      rand_set(0);
      send(0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    clear_model();
    @(negedge clk);
    iv = '0;
    rst = 1'b0;
    clear_model();
    repeat (4) step();
    step();
    rand_set(0);
    send(0);
    repeat (6) step();

    for (int d = 0; d < 4; d++)
      chk($sformatf("drain%0d", d), 32'(q[d].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
